seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits (2..16).
REQ-002 Parameter CNT_W, default 8: width of match counter.
REQ-003 Parameter RST_PATTERN, default 8'b0000_1011: pattern after reset, right-aligned, LSB is last bit received.
REQ-004 Parameter RST_LEN, default 4: pattern length after reset.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 x  in  1  serial data bit.
REQ-008 x_valid  in  1  x sampled only on edges where x_valid=1.
REQ-009 cfg_load  in  1  one-cycle pulse; latches cfg_pattern, cfg_len and cfg_overlap.
REQ-010 cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
REQ-011 cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
REQ-012 cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-013 cnt_clr  in  1  clears match_count.
REQ-014 z  out  1  Moore match output, registered.
REQ-015 match_count  out  CNT_W  number of matches since reset/clear.

Function
REQ-016 Block SHALL keep a MAX_LEN-bit history register (new bit shifted into LSB on each accepted sample) and a fill counter saturating at MAX_LEN.
REQ-017 A match SHALL occur on an accepted sample when fill (including this bit) >= LEN and the low LEN history bits (including this bit) equal the low LEN pattern bits.
REQ-018 z SHALL be 1 for exactly one clk cycle following the edge that accepted the final matching bit, else 0; z SHALL depend only on registered state.
REQ-019 Overlap mode 1: history and fill retained after match (1011 on 1011011 gives 2 matches).
REQ-020 Overlap mode 0: fill SHALL be cleared to 0 on the match edge (1011 on 1011011 gives 1 match).
REQ-021 Edges with x_valid=0 SHALL leave history and fill unchanged; z still drops after its one cycle.
REQ-022 cfg_len of 0 or 1 SHALL be treated as 1; cfg_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-023 On cfg_load the block SHALL latch configuration, clear history, fill and z on the same edge, and discard any simultaneous x sample.
REQ-024 match_count SHALL increment by 1 on each match edge and saturate at 2^CNT_W-1.
REQ-025 cnt_clr with a simultaneous match SHALL load match_count = 1; cnt_clr alone SHALL load 0.
REQ-026 cfg_load SHALL NOT alter match_count.

Reset
REQ-027 On reset=1 at a rising edge: pattern=RST_PATTERN, LEN=RST_LEN, overlap=1, history=0, fill=0, z=0, match_count=0.
REQ-028 reset SHALL override cfg_load, cnt_clr and x_valid on the same edge; reset mid-sequence discards partial progress.

Configuration
REQ-029 Macro SEQ_DETECT_COUNT_EN defined: match counter and cnt_clr behave per REQ-024..026.
REQ-030 Macro SEQ_DETECT_COUNT_EN undefined: no counter registers; match_count tied to 0, cnt_clr ignored; z behaviour unchanged.

Structure
REQ-031 Package seq_detect_pkg SHALL hold default constants (MAX_LEN, CNT_W, RST_PATTERN, RST_LEN) and a function for length clamping.
REQ-032 Sub-module seq_match_cmp SHALL implement the length-masked compare of history against pattern (combinational, parameterised by MAX_LEN).

Verification
REQ-033 Reset defaults, overlap=1, x=1,0,1,1,0,1,1 all valid -> z pulses after bit 4 and bit 7, match_count=2.
REQ-034 Same stream after cfg_load overlap=0, pattern 1011, len 4 -> single z pulse after bit 4, match_count=1.
REQ-035 x_valid toggling 1,0,1,0... with data 1,0,1,1 on valid cycles -> one z pulse, one cycle wide, after 4th valid edge.
REQ-036 cfg_len=12 with MAX_LEN=8, pattern 8'hFF, eight 1s -> match after 8th bit; cfg_len=0, pattern bit0=1 -> match on every valid 1.
REQ-037 CNT_W=2, six matches -> match_count saturates at 3; cnt_clr with match -> 1.
REQ-038 reset asserted after receiving 1,0,1 then x=1 -> no z pulse; cfg_load coincident with final bit -> no z pulse.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the parameterised serial sequence detector.
package seq_detect_pkg;

    localparam int         DEF_MAX_LEN     = 8;
    localparam int         DEF_CNT_W       = 8;
    localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_1011;
    localparam int         DEF_RST_LEN     = 4;

    // Pattern lengths below 1 behave as 1; lengths above the history depth saturate.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1)
            return 1;
        else if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Length-masked comparison of the shift history against the active pattern.
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    logic [MAX_LEN-1:0] mask;

    // Only the low len bits take part in the compare.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign mask[i] = (len > LEN_W'(i));
    end

    assign eq = (((hist ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional match counter is built when SEQ_DETECT_COUNT_EN is defined; otherwise
// match_count reads as 0 and cnt_clr is ignored.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int                 RST_LEN     = DEF_RST_LEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         z,
    output logic [CNT_W-1:0]             match_count
);

    localparam int               LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               hist_eq;
    logic               match;

    // History and fill as they would look after accepting the current bit.
    assign hist_shift = {hist_q[MAX_LEN-2:0], x};
    assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist    (hist_shift),
        .pattern (pattern_q),
        .len     (len_q),
        .eq      (hist_eq)
    );

    // A sample coinciding with cfg_load is discarded, so it can never match.
    assign match = x_valid && !cfg_load && (fill_inc >= len_q) && hist_eq;

    // Next-state for configuration, history, fill and the Moore match flag.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        z_d       = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            hist_d = hist_shift;
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
            z_d    = match;
        end
    end

    // Register update; reset restores the power-on pattern in overlap mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN_C;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            z_q       <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            z_q       <= z_d;
        end
    end

    assign z = z_q;

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear on a match edge counts that match.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = match ? CNT_W'(1) : '0;
        else if (match && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
